// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//                restoring divide on operand magnitudes, one iteration per
//                clock, with sign fix-up on the final edge. Divide-by-zero and
//                signed overflow finish in one cycle.
//                Optional macro MULDIV_FAST_MUL_EN: MUL* ops compute the full
//                product in one cycle instead of iterating.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            wb_en,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;      // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;      // multiplier bits / dividend-to-quotient
    logic [XLEN-1:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
    logic            neg_q, neg_d;    // negate the final result
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode at the start edge
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div_zero, w_div_ovf, w_fast_div;
    logic [XLEN-1:0] w_fast_div_res;

    // One iteration step and final fix-up
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ok;
    logic [XLEN-1:0]   w_hi_n, w_lo_n;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_div_sel, w_final;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod, w_fast_prod_s;
    logic [XLEN-1:0]   w_fast_mul_res;
`endif

    // Sign handling, magnitudes and divide special cases from the live operands
    always_comb begin
        w_a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
        w_b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        w_a_neg    = w_a_signed & rs1_data[XLEN-1];
        w_b_neg    = w_b_signed & rs2_data[XLEN-1];
        w_a_mag    = w_a_neg ? ({XLEN{1'b0}} - rs1_data) : rs1_data;
        w_b_mag    = w_b_neg ? ({XLEN{1'b0}} - rs2_data) : rs2_data;
        w_div_zero = (rs2_data == {XLEN{1'b0}});
        // Signed overflow only exists for DIV/REM (funct3[0]==0 among divides)
        w_div_ovf  = ~funct3[0] && (rs1_data == MOST_NEG) && (rs2_data == {XLEN{1'b1}});
        w_fast_div = funct3[2] && (w_div_zero || w_div_ovf);
        if (w_div_zero) begin
            w_fast_div_res = funct3[1] ? rs1_data : {XLEN{1'b1}};
        end else begin
            w_fast_div_res = funct3[1] ? {XLEN{1'b0}} : rs1_data;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle multiply on magnitudes with sign correction
    always_comb begin
        w_fast_prod    = w_a_mag * w_b_mag;
        w_fast_prod_s  = (w_a_neg ^ w_b_neg) ? ({(2*XLEN){1'b0}} - w_fast_prod) : w_fast_prod;
        w_fast_mul_res = (funct3 == F3_MUL) ? w_fast_prod_s[XLEN-1:0]
                                            : w_fast_prod_s[2*XLEN-1:XLEN];
    end
`endif

    // One shift-add or restoring-divide step, plus the result it would yield if last
    always_comb begin
        w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        w_div_shift = {hi_q, lo_q[XLEN-1]};
        w_div_ok    = (w_div_shift >= {1'b0, opnd_q});
        if (op_q[2]) begin
            // Partial remainder stays below the divisor, so XLEN bits suffice
            w_hi_n = w_div_ok ? (w_div_shift[XLEN-1:0] - opnd_q) : w_div_shift[XLEN-1:0];
            w_lo_n = {lo_q[XLEN-2:0], w_div_ok};
        end else begin
            w_hi_n = w_mul_sum[XLEN:1];
            w_lo_n = {w_mul_sum[0], lo_q[XLEN-1:1]};
        end
        w_prod    = {w_hi_n, w_lo_n};
        w_prod_s  = neg_q ? ({(2*XLEN){1'b0}} - w_prod) : w_prod;
        w_div_sel = op_q[1] ? w_hi_n : w_lo_n;
        if (op_q[2]) begin
            w_final = neg_q ? ({XLEN{1'b0}} - w_div_sel) : w_div_sel;
        end else if (op_q == F3_MUL) begin
            w_final = w_prod_s[XLEN-1:0];
        end else begin
            w_final = w_prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    op_d  = funct3;
                    rd_d  = rd_in;
                    cnt_d = '0;
                    // REM follows the dividend sign; everything else the sign product
                    neg_d = (funct3 == F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
                    hi_d  = '0;
                    if (w_fast_div) begin
                        result_d = w_fast_div_res;
                        state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!funct3[2]) begin
                        result_d = w_fast_mul_res;
                        state_d  = S_DONE;
`endif
                    end else begin
                        opnd_d  = funct3[2] ? w_b_mag : w_a_mag;
                        lo_d    = funct3[2] ? w_a_mag : w_b_mag;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                hi_d  = w_hi_n;
                lo_d  = w_lo_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_d = w_final;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Flush aborts everything and leaves the visible result untouched
        if (kill) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    // Status and write-back outputs; a flush in DONE suppresses the write
    always_comb begin
        busy   = (state_q != S_IDLE);
        wb_en  = (state_q == S_DONE) && !kill;
        result = result_q;
        rd_out = rd_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit: directed vector table,
//                randomized ops against an arithmetic reference model, and
//                kill / mid-run reset / busy-start sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT  = 33;
    localparam int FAST_LAT = 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        kill;
    logic        busy;
    logic        wb_en;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int tests_run = 0;
    int tests_failed = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .kill     (kill),
        .busy     (busy),
        .wb_en    (wb_en),
        .result   (result),
        .rd_out   (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RV32M rules computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [63:0] uprod;
        logic [31:0] r;
        logic        ovf;
        sa    = $signed({{32{a[31]}}, a});
        sb    = $signed({{32{b[31]}}, b});
        ub    = {32'b0, b};
        uprod = {32'b0, a} * {32'b0, b};
        ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r     = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: r = uprod[63:32];
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 0) return FAST_LAT;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return FAST_LAT;
        return DIV_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue one op and watch 40 cycles; latency = cycles from start cycle to first wb_en
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit noise,
                          output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int pulses);
        res = '0; rdo = '0; lat = 0; pulses = 0;
        @(posedge clk); #1;
        funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
        for (int k = 1; k <= 40; k++) begin
            if (noise && k <= 20) begin
                start = 1'b1; funct3 = 3'($urandom);
                rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (wb_en) begin
                pulses++;
                if (lat == 0) begin lat = k; res = result; rdo = rd_out; end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    vec_t        vecs[$];
    logic [31:0] res;
    logic [4:0]  rdo;
    int          lat, pulses;

    initial begin
        rst_n = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0;
        rd_in = '0; kill = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",   {31'b0, busy},   32'h0);
        check("reset wb_en",  {31'b0, wb_en},  32'h0);
        check("reset result", result,          32'h0);
        check("reset rd_out", {27'b0, rd_out}, 32'h0);
        rst_n = 1'b1;

        vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, MUL_LAT});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, MUL_LAT});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, MUL_LAT});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, MUL_LAT});
        vecs.push_back('{3'd4, 32'hFFFF_FFEC,  32'd3,         5'd9,  32'hFFFF_FFFA, DIV_LAT});
        vecs.push_back('{3'd6, 32'hFFFF_FFEC,  32'd3,         5'd10, 32'hFFFF_FFFE, DIV_LAT});
        vecs.push_back('{3'd5, 32'd20,         32'd3,         5'd11, 32'd6,         DIV_LAT});
        vecs.push_back('{3'd7, 32'd20,         32'd3,         5'd12, 32'd2,         DIV_LAT});
        vecs.push_back('{3'd4, 32'h1234,       32'd0,         5'd13, 32'hFFFF_FFFF, FAST_LAT});
        vecs.push_back('{3'd6, 32'h1234,       32'd0,         5'd14, 32'h1234,      FAST_LAT});
        vecs.push_back('{3'd5, 32'h1234,       32'd0,         5'd15, 32'hFFFF_FFFF, FAST_LAT});
        vecs.push_back('{3'd7, 32'h1234,       32'd0,         5'd16, 32'h1234,      FAST_LAT});
        vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'h8000_0000, FAST_LAT});
        vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'h0,         FAST_LAT});
        vecs.push_back('{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h0,         DIV_LAT});
        vecs.push_back('{3'd0, 32'h0001_0000,  32'h0001_0000, 5'd0,  32'h0,         MUL_LAT});
        vecs.push_back('{3'd3, 32'h0001_0000,  32'h0001_0000, 5'd31, 32'h1,         MUL_LAT});

        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b0, res, rdo, lat, pulses);
            check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d rd_out", i), {27'b0, rdo}, {27'b0, vecs[i].rd});
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d wb pulses", i), pulses, 1);
        end

        for (int n = 0; n < 150; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  rd;
            f3 = 3'($urandom); a = pick_operand(); b = pick_operand(); rd = 5'($urandom);
            run_op(f3, a, b, rd, 1'b0, res, rdo, lat, pulses);
            check($sformatf("rnd%0d f3=%0d a=%08h b=%08h result", n, f3, a, b), res,
                  ref_model(f3, a, b));
            check($sformatf("rnd%0d latency", n), lat, ref_lat(f3, a, b));
        end

        // start pulses while busy are ignored
        run_op(3'd5, 32'd20, 32'd3, 5'd7, 1'b1, res, rdo, lat, pulses);
        check("busy-start result",  res, 32'd6);
        check("busy-start rd_out",  {27'b0, rdo}, 32'd7);
        check("busy-start latency", lat, DIV_LAT);
        check("busy-start pulses",  pulses, 1);

        // kill at iteration 10 of a DIV
        @(posedge clk); #1;
        funct3 = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("kill pre busy", {31'b0, busy}, 32'h1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill post busy", {31'b0, busy}, 32'h0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wb_en) pulses++;
        end
        check("kill wb pulses", pulses, 0);
        check("kill result kept", result, 32'd6);

        // kill together with start in IDLE drops the request
        @(posedge clk); #1;
        funct3 = 3'd5; rs1_data = 32'd9; rs2_data = 32'd0; rd_in = 5'd4;
        start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("idle kill busy", {31'b0, busy}, 32'h0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (wb_en) pulses++;
        end
        check("idle kill pulses", pulses, 0);
        check("idle kill result", result, 32'd6);

        // async reset mid-RUN
        @(posedge clk); #1;
        funct3 = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy",   {31'b0, busy},   32'h0);
        check("midrst wb_en",  {31'b0, wb_en},  32'h0);
        check("midrst result", result,          32'h0);
        check("midrst rd_out", {27'b0, rd_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd21, 1'b0, res, rdo, lat, pulses);
        check("post-rst result",  res, 32'hFFFF_FFFA);
        check("post-rst rd_out",  {27'b0, rdo}, 32'd21);
        check("post-rst latency", lat, DIV_LAT);
        check("post-rst pulses",  pulses, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
